// File: rtl/rom_share_arbiter_if.sv
// Bus between the pixel requesters, the shared image ROM and rom_share_arbiter.
// Signal names follow the arbiter's original port names for drop-in compatibility.
interface rom_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*ADDR_W-1:0] addr_in;
  logic [NUM_REQ-1:0]        gnt_out;
  logic [ADDR_W-1:0]         rom_addr_out;
  logic [DATA_W-1:0]         rom_data_in;
  logic [NUM_REQ-1:0]        valid_out;
  logic [DATA_W-1:0]         data_out;

  modport master (
    output req_in, addr_in, rom_data_in,
    input  gnt_out, rom_addr_out, valid_out, data_out
  );

  modport slave (
    input  req_in, addr_in, rom_data_in,
    output gnt_out, rom_addr_out, valid_out, data_out
  );
endinterface

// File: rtl/rom_share_arbiter.sv
// Round-robin sharing of one registered-output image ROM among NUM_REQ blobs,
// with a tag pipeline that returns each word to its requester ROM_LAT+2 cycles after grant.
module rom_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROM_LAT = 1
) (
  input logic              pixel_clk_in,
  input logic              rst_in,
  rom_share_arbiter_if.slave bus
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NUM_REQ-1:0] valid_q;
  logic [DATA_W-1:0]  data_q;
  tag_t               tag_q [ROM_LAT+1];

  logic [NUM_REQ-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  int unsigned        idx;
  logic [ID_W-1:0]    idx_w;

  // First requester at or after ptr wins; grant is suppressed while reset is held.
  always_comb begin
    gnt_d   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(ptr_q) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!gnt_any && bus.req_in[idx_w]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_w;
      end
    end
    if (rst_in) begin
      gnt_any = 1'b0;
    end
    if (gnt_any) begin
      gnt_d[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    addr_d = bus.addr_in[gnt_id*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr_q  <= ptr_d;
        addr_q <= addr_d;
      end
      tag_q[0] <= '{v: gnt_any, id: gnt_id};
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // Last tag stage lines up with the ROM's read data for the same grant.
      if (tag_q[ROM_LAT].v) begin
        valid_q <= NUM_REQ'(1) << tag_q[ROM_LAT].id;
        data_q  <= bus.rom_data_in;
      end else begin
        valid_q <= '0;
      end
    end
  end

  assign bus.gnt_out      = gnt_d;
  assign bus.rom_addr_out = addr_q;
  assign bus.valid_out    = valid_q;
  assign bus.data_out     = data_q;
endmodule

// File: tb/tb_rom_share_arbiter.sv
// Bench for rom_share_arbiter: ROM_LAT=1 and ROM_LAT=3 instances driven in lockstep and
// compared each cycle against a queue-based model of grants and returns.
module tb_rom_share_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_share_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
  rom_share_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus3 ();

  rom_share_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut1 (
    .pixel_clk_in(clk), .rst_in(rst), .bus(bus1));
  rom_share_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_dut3 (
    .pixel_clk_in(clk), .rst_in(rst), .bus(bus3));

  // ROM contents: data = addr[7:0], delivered ROM_LAT edges after the address.
  logic [7:0] rom1_q;
  logic [7:0] rom3_q [3];
  always @(posedge clk) begin
    rom1_q    <= bus1.rom_addr_out[7:0];
    rom3_q[0] <= bus3.rom_addr_out[7:0];
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign bus1.rom_data_in = rom1_q;
  assign bus3.rom_data_in = rom3_q[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         id;
    logic [7:0] d;
  } ret_t;

  ret_t        q1[$];
  ret_t        q3[$];
  logic [7:0]  dl1 = '0, dl3 = '0;
  logic [15:0] ra_m = '0;
  int          ptr_m = 0;
  int          last_g = -1;
  int          total = 0, bad = 0;
  int          gnt_cnt = 0, ret_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [NR*AW-1:0] pack(input logic [15:0] a0, input logic [15:0] a1,
                                            input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check_state();
    logic [NR-1:0] ev1, ev3;
    logic [7:0]    ed1, ed3;
    ev1 = '0; ed1 = dl1;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      ev1 = NR'(1) << q1[0].id; ed1 = q1[0].d; dl1 = ed1; q1.delete(0);
    end
    ev3 = '0; ed3 = dl3;
    if (q3.size() > 0 && q3[0].due == cyc) begin
      ev3 = NR'(1) << q3[0].id; ed3 = q3[0].d; dl3 = ed3; q3.delete(0);
    end
    chk("valid_l1", 64'(bus1.valid_out), 64'(ev1));
    chk("data_l1", 64'(bus1.data_out), 64'(ed1));
    chk("valid_l3", 64'(bus3.valid_out), 64'(ev3));
    chk("data_l3", 64'(bus3.data_out), 64'(ed3));
    chk("romaddr_l1", 64'(bus1.rom_addr_out), 64'(ra_m));
    chk("romaddr_l3", 64'(bus3.rom_addr_out), 64'(ra_m));
    ret_cnt += $countones(bus1.valid_out);
  endtask

  // One clock cycle: check registered outputs, drive inputs, then check the grant.
  task automatic cycle(input logic r, input logic [NR-1:0] req, input logic [NR*AW-1:0] addr);
    int            g;
    logic [NR-1:0] eg;
    @(negedge clk);
    check_state();
    rst = r;
    bus1.req_in = req;  bus3.req_in = req;
    bus1.addr_in = addr; bus3.addr_in = addr;
    #1;
    g = -1;
    if (r) begin
      q1.delete(); q3.delete();
      dl1 = '0; dl3 = '0; ra_m = '0; ptr_m = 0;
      chk("rst_valid", 64'(bus1.valid_out | bus3.valid_out), 64'd0);
      chk("rst_data", 64'(bus1.data_out | bus3.data_out), 64'd0);
      chk("rst_romaddr", 64'(bus1.rom_addr_out | bus3.rom_addr_out), 64'd0);
    end else begin
      for (int k = 0; k < int'(NR); k++) begin
        int i;
        i = (ptr_m + k) % NR;
        if (g < 0 && req[i]) g = i;
      end
    end
    eg = (g < 0) ? '0 : NR'(1) << g;
    chk("gnt_l1", 64'(bus1.gnt_out), 64'(eg));
    chk("gnt_l3", 64'(bus3.gnt_out), 64'(eg));
    gnt_cnt += $countones(bus1.gnt_out);
    if (g >= 0) begin
      ptr_m = (g + 1) % NR;
      ra_m  = addr[g*AW +: AW];
      q1.push_back('{due: cyc + 3, id: g, d: ra_m[7:0]});
      q3.push_back('{due: cyc + 5, id: g, d: ra_m[7:0]});
    end
    last_g = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  logic [NR-1:0]    cur_req;
  logic [NR*AW-1:0] cur_addr;
  int               g0, r0;

  initial begin
    bus1.req_in = '0; bus3.req_in = '0;
    bus1.addr_in = '0; bus3.addr_in = '0;
    cycle(1'b1, '0, '0);
    cycle(1'b1, '0, '0);
    idle(2);

    // Reset with two reads in flight, requests held during reset, quiet after release.
    cycle(1'b0, 4'b0011, pack(16'hA011, 16'hA122, 16'h0, 16'h0));
    cycle(1'b0, 4'b0011, pack(16'hA011, 16'hA122, 16'h0, 16'h0));
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, pack(16'h1, 16'h2, 16'h3, 16'h4));
    idle(5);
    cycle(1'b0, 4'b1010, pack(16'h0, 16'hBEEF, 16'h0, 16'hCAFE));
    idle(6);

    // Single requester.
    cycle(1'b0, 4'b0100, pack(16'h0, 16'h0, 16'h1234, 16'h0));
    idle(6);

    // All four continuously requesting.
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, pack(16'h10, 16'h20, 16'h30, 16'h40));
    idle(6);

    // Pointer wrap 3 -> 0 -> 3.
    cycle(1'b0, 4'b0100, pack(16'h0, 16'h0, 16'h0055, 16'h0));
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1001, pack(16'h0077, 16'h0, 16'h0, 16'h0099));
    idle(6);

    // Held requester 1 with a one-cycle pulse from requester 2.
    g0 = gnt_cnt; r0 = ret_cnt;
    for (int i = 0; i < 7; i++)
      cycle(1'b0, (i == 2) ? 4'b0110 : 4'b0010, pack(16'h0, 16'h0100 + 16'(i), 16'h02EE, 16'h0));
    idle(6);
    chk("mix_grants", 64'(gnt_cnt - g0), 64'd7);
    chk("mix_returns", 64'(ret_cnt - r0), 64'd7);

    // Random traffic with occasional reset.
    cur_req = '0;
    cur_addr = '0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < int'(NR); i++) begin
        if (cur_req[i] && i == last_g) begin
          cur_addr[i*AW +: AW] = 16'($urandom);
          cur_req[i] = ($urandom_range(0, 3) != 0);
        end else if (cur_req[i]) begin
          cur_req[i] = ($urandom_range(0, 15) != 0);
        end else begin
          cur_req[i] = $urandom_range(0, 1) == 1;
          if (cur_req[i]) cur_addr[i*AW +: AW] = 16'($urandom);
        end
      end
      cycle(r, cur_req, cur_addr);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
